// File: rtl/param_regfile_sb.sv
//------------------------------------------------------------------------------
// param_regfile_sb : 2-read / 2-write register file with bypass and busy board
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  input  logic              we,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] busw,
  input  logic              we2,
  input  logic [ADDR_W-1:0] rw2,
  input  logic [DATA_W-1:0] busw2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_cnt,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic              w_wen0;
  logic              w_wen1;
  logic              w_iss;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;
  logic              w_inc;
  logic              w_dec0;
  logic              w_dec1;

  // Address 0 is filtered here so neither storage, bypass nor scoreboard sees it.
  assign w_wen0 = we       && ((ZERO_REG == 0) || (rw       != '0));
  assign w_wen1 = we2      && ((ZERO_REG == 0) || (rw2      != '0));
  assign w_iss  = issue_en && ((ZERO_REG == 0) || (issue_rd != '0));

  for (genvar i = 0; i < NREGS; i++) begin : g_busy
    assign w_set[i] = w_iss && (issue_rd == ADDR_W'(i));
    assign w_clr[i] = (w_wen0 && (rw  == ADDR_W'(i))) ||
                      (w_wen1 && (rw2 == ADDR_W'(i)));
  end

  assign busy_d = w_set | (busy_q & ~w_clr);

  // Incremental popcount: a clear only counts if the bit was set and is not re-set.
  assign w_inc  = w_iss && !busy_q[issue_rd];
  assign w_dec0 = w_wen0 && busy_q[rw] && !(w_iss && (issue_rd == rw));
  assign w_dec1 = w_wen1 && busy_q[rw2] && !(w_iss && (issue_rd == rw2)) &&
                  !(w_wen0 && (rw == rw2));
  assign cnt_d  = cnt_q + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec0)
                        - (ADDR_W+1)'(w_dec1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Port 0 is assigned last so it wins a same-address collision.
      if (w_wen1) regs_q[rw2] <= busw2;
      if (w_wen0) regs_q[rw]  <= busw;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busa   = regs_q[ra];
    busb   = regs_q[rb];
    busy_a = busy_q[ra];
    busy_b = busy_q[rb];
    if (BYPASS != 0) begin
      if (w_wen0 && (rw == ra))       busa = busw;
      else if (w_wen1 && (rw2 == ra)) busa = busw2;
      if (w_wen0 && (rw == rb))       busb = busw;
      else if (w_wen1 && (rw2 == rb)) busb = busw2;
      if (w_clr[ra]) busy_a = 1'b0;
      if (w_clr[rb]) busy_b = 1'b0;
    end
  end

  assign busy_cnt = cnt_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

`default_nettype wire
